// File: rtl/sm_uart_loader_pkg.sv
// sm_uart_loader_pkg: loader state encoding, default sizing and counter-width helper
package sm_uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_BYTE,
        WRITE,
        RELEASE
    } loaderState_t;

    localparam int DEF_WORDS    = 16;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_TIMEOUT  = 1048576;
    localparam int DEF_RST_HOLD = 2;

    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sm_uart_loader_asm.sv
// sm_uart_loader_asm: packs UART bytes MSB-first into 32-bit words, flags the completing byte
module sm_uart_loader_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic [31:0] word,
    output logic        wordValid
);

    logic [23:0] shift;
    logic [1:0]  byteCnt;
    logic        take;

    assign take      = en && rxValid;
    assign word      = {shift, rxData};
    assign wordValid = take && (byteCnt == 2'd3);

    // shift in each accepted byte and count position within the word (wraps every 4)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            byteCnt <= '0;
        end else if (clr) begin
            shift   <= '0;
            byteCnt <= '0;
        end else if (take) begin
            shift   <= {shift[15:0], rxData};
            byteCnt <= byteCnt + 2'd1;
        end
    end

endmodule

// File: rtl/sm_uart_loader.sv
// sm_uart_loader: holds the CPU in reset, zero-fills the ROM, then loads UART words into it
module sm_uart_loader
    import sm_uart_loader_pkg::*;
#(
    parameter int WORDS    = DEF_WORDS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int RST_HOLD = DEF_RST_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TW   = cntWidth(TIMEOUT);
    localparam int HOLD = (RST_HOLD < 1) ? 1 : RST_HOLD;
    localparam int HW   = cntWidth(HOLD);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     TO_MAX    = TW'(TIMEOUT);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD - 1);

    loaderState_t  state;
    logic          loadReqQ;
    logic          loadEdge;
    logic [TW-1:0] idleCnt;
    logic [HW-1:0] holdCnt;
    logic [31:0]   word;
    logic          wordValid;

    assign loadEdge = load_req && !loadReqQ;

    sm_uart_loader_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == IDLE),
        .en        (state == WAIT_BYTE || state == WRITE),
        .rxData    (rx_data),
        .rxValid   (rx_valid),
        .word      (word),
        .wordValid (wordValid)
    );

    // loader sequencing: clear sweep, byte wait with timeout, word write, reset-hold release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            loadReqQ  <= 1'b0;
            idleCnt   <= '0;
            holdCnt   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            loadReqQ <= load_req;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (loadEdge) begin
                        state     <= CLEAR;
                        cpu_rst   <= 1'b1;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        idleCnt   <= '0;
                        holdCnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (mem_addr == LAST_ADDR) begin
                        state    <= WAIT_BYTE;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                WAIT_BYTE: begin
                    if (wordValid) begin
                        state     <= WRITE;
                        mem_we    <= 1'b1;
                        mem_wdata <= word;
                        idleCnt   <= '0;
                    end else if (rx_valid) begin
                        idleCnt <= '0;
                    end else if (idleCnt == TO_LAST) begin
                        idleCnt <= TO_MAX;
                        err     <= 1'b1;
                        holdCnt <= '0;
                        state   <= RELEASE;
                    end else if (idleCnt != TO_MAX) begin
                        idleCnt <= idleCnt + TW'(1);
                    end
                end
                WRITE: begin
                    mem_we  <= 1'b0;
                    idleCnt <= '0;
                    if (mem_addr == LAST_ADDR) begin
                        holdCnt <= '0;
                        state   <= RELEASE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= WAIT_BYTE;
                    end
                end
                RELEASE: begin
                    if (holdCnt == HOLD_LAST) begin
                        state   <= IDLE;
                        cpu_rst <= 1'b0;
                        busy    <= 1'b0;
                        done    <= !err;
                    end else begin
                        holdCnt <= holdCnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_uart_loader.sv
// tb_sm_uart_loader: scoreboarded ROM writes plus clear, load, timeout, retrigger and abort scenarios
module tb_sm_uart_loader;

    localparam int WORDS    = 16;
    localparam int ADDR_W   = 5;
    localparam int TIMEOUT  = 100;
    localparam int RST_HOLD = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_req = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;
    int lastWe = 0;

    logic [ADDR_W+31:0] sbq[$];
    logic [ADDR_W+31:0] sbE;
    logic [31:0]        rom[WORDS];
    logic [31:0]        expRom[WORDS];

    sm_uart_loader #(
        .WORDS    (WORDS),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // every ROM write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            nChecks++;
            if (sbq.size() == 0) begin
                $display("FAIL write_unexpected addr=%0d data=%h required=no write", mem_addr, mem_wdata);
            end else begin
                sbE = sbq.pop_front();
                if ({mem_addr, mem_wdata} !== sbE)
                    $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                             mem_addr, mem_wdata, sbE[ADDR_W+31:32], sbE[31:0]);
                else
                    nPass++;
            end
            rom[mem_addr] = mem_wdata;
            lastWe = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic sendWord(input int a, input logic [31:0] w);
        sbq.push_back({ADDR_W'(a), w});
        expRom[a] = w;
        for (int i = 3; i >= 0; i--) sendByte(w[8*i +: 8]);
    endtask

    task automatic startLoad();
        load_req = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            sbq.push_back({ADDR_W'(i), 32'h0});
            expRom[i] = 32'h0;
        end
    endtask

    function automatic logic [31:0] mkWord(input int i);
        return {8'(i * 17), 8'(8'h5A ^ 8'(i)), 8'(i), 8'(8'hC3 - 8'(i))};
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        step(2);
        @(negedge clk);
        nChecks++;
        if ({mem_we, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_mem got=%h required=0", {mem_we, mem_addr, mem_wdata});
        else nPass++;
        nChecks++;
        if ({cpu_rst, busy, done, err} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b required=0000", {cpu_rst, busy, done, err});
        else nPass++;
        step();
        rst = 1'b0;
        step();
        sendByte(8'hEE);
        @(negedge clk);
        nChecks++;
        if ({mem_we, busy} !== 2'b00)
            $display("FAIL idle_rx_ignored got=%b required=00", {mem_we, busy});
        else nPass++;
        step();
    endtask

    task automatic test_clear();
        int weCnt = 0;
        startLoad();
        step();
        @(negedge clk);
        nChecks++;
        if ({busy, cpu_rst, mem_we, mem_addr} !== {3'b111, ADDR_W'(0)})
            $display("FAIL clear_start got=%b required=111_00000", {busy, cpu_rst, mem_we, mem_addr});
        else nPass++;
        for (int k = 1; k <= 20; k++) begin
            if (mem_we) weCnt++;
            if (k == 3) load_req = 1'b0;
            if (k == 5) begin rx_data = 8'hFF; rx_valid = 1'b1; end
            if (k == 6) begin rx_valid = 1'b0; load_req = 1'b1; end
            if (k == 10) load_req = 1'b0;
            @(negedge clk);
        end
        nChecks++;
        if (weCnt !== WORDS) $display("FAIL clear_we_cycles got=%0d required=%0d", weCnt, WORDS);
        else nPass++;
        nChecks++;
        if (sbq.size() !== 0) $display("FAIL clear_pending got=%0d required=0", sbq.size());
        else nPass++;
        nChecks++;
        if ({busy, cpu_rst, mem_we} !== 3'b110)
            $display("FAIL clear_end got=%b required=110", {busy, cpu_rst, mem_we});
        else nPass++;
        step();
    endtask

    task automatic test_single_word();
        sbq.push_back({ADDR_W'(0), 32'h00100073});
        expRom[0] = 32'h00100073;
        sendByte(8'h00); step();
        sendByte(8'h10); step();
        sendByte(8'h00); step();
        sendByte(8'h73);
        @(negedge clk);
        nChecks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ADDR_W'(0), 32'h00100073})
            $display("FAIL single_word got we=%b addr=%0d data=%h required we=1 addr=0 data=00100073",
                     mem_we, mem_addr, mem_wdata);
        else nPass++;
        step();
        @(negedge clk);
        nChecks++;
        if (mem_we !== 1'b0) $display("FAIL single_word_pulse got=%b required=0", mem_we);
        else nPass++;
        step();
    endtask

    task automatic test_full_load(input int first, input bit fresh);
        int doneCyc = 0;
        int doneCnt = 0;
        logic prevRst = 1'b1;
        logic rstAtDone = 1'b1;
        logic rstBefore = 1'b0;
        if (fresh) begin
            startLoad();
            step(18);
            load_req = 1'b0;
        end
        for (int a = first; a < WORDS; a++) sendWord(a, mkWord(a));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if (doneCyc == 0) begin
                    doneCyc = cyc;
                    rstAtDone = cpu_rst;
                    rstBefore = prevRst;
                end
            end
            prevRst = cpu_rst;
        end
        nChecks++;
        if (doneCyc !== lastWe + 1 + RST_HOLD)
            $display("FAIL load_done_time got=%0d required=%0d", doneCyc, lastWe + 1 + RST_HOLD);
        else nPass++;
        nChecks++;
        if (doneCnt !== 1) $display("FAIL load_done_width got=%0d required=1", doneCnt);
        else nPass++;
        nChecks++;
        if ({rstBefore, rstAtDone} !== 2'b10)
            $display("FAIL load_cpu_rst_fall got=%b required=10", {rstBefore, rstAtDone});
        else nPass++;
        nChecks++;
        if ({busy, err, cpu_rst} !== 3'b000)
            $display("FAIL load_idle got=%b required=000", {busy, err, cpu_rst});
        else nPass++;
        nChecks++;
        if (sbq.size() !== 0) $display("FAIL load_pending got=%0d required=0", sbq.size());
        else nPass++;
        for (int a = 0; a < WORDS; a++) begin
            nChecks++;
            if (rom[a] !== expRom[a]) $display("FAIL load_rom[%0d] got=%h required=%h", a, rom[a], expRom[a]);
            else nPass++;
        end
        step();
    endtask

    task automatic test_timeout();
        int errAt = 0;
        int relAt = 0;
        int doneSeen = 0;
        startLoad();
        step(18);
        sendWord(0, 32'hDEADBEEF);
        sendWord(1, 32'h12345678);
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (k == 20) load_req = 1'b0;
            if (k == 25) load_req = 1'b1;
            if (err && errAt == 0) errAt = k;
            if (!cpu_rst && relAt == 0) relAt = k;
            if (done) doneSeen++;
        end
        nChecks++;
        if (!(errAt >= TIMEOUT - 5 && errAt <= TIMEOUT + 10))
            $display("FAIL timeout_err_time got=%0d required=%0d..%0d", errAt, TIMEOUT - 5, TIMEOUT + 10);
        else nPass++;
        nChecks++;
        if (relAt !== errAt + RST_HOLD)
            $display("FAIL timeout_release got=%0d required=%0d", relAt, errAt + RST_HOLD);
        else nPass++;
        nChecks++;
        if (doneSeen !== 0) $display("FAIL timeout_done got=%0d required=0", doneSeen);
        else nPass++;
        nChecks++;
        if ({busy, err, cpu_rst} !== 3'b010)
            $display("FAIL timeout_idle_held got=%b required=010", {busy, err, cpu_rst});
        else nPass++;
        nChecks++;
        if (sbq.size() !== 0) $display("FAIL timeout_pending got=%0d required=0", sbq.size());
        else nPass++;
        for (int a = 0; a < WORDS; a++) begin
            nChecks++;
            if (rom[a] !== expRom[a]) $display("FAIL timeout_rom[%0d] got=%h required=%h", a, rom[a], expRom[a]);
            else nPass++;
        end
        step();
    endtask

    task automatic test_restart();
        load_req = 1'b0;
        step();
        startLoad();
        step();
        @(negedge clk);
        nChecks++;
        if ({err, busy} !== 2'b01) $display("FAIL restart_err_clear got=%b required=01", {err, busy});
        else nPass++;
        step(17);
    endtask

    task automatic test_async_reset();
        for (int a = 0; a < 4; a++) sendWord(a, mkWord(a + 100));
        sbq.push_back({ADDR_W'(4), 32'h0BADF00D});
        sendByte(8'h0B);
        sendByte(8'hAD);
        nChecks++;
        if ({busy, cpu_rst} !== 2'b11) $display("FAIL abort_pre got=%b required=11", {busy, cpu_rst});
        else nPass++;
        #2 rst = 1'b1;
        #1;
        nChecks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err} !== '0)
            $display("FAIL abort_async got=%h required=0", {mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err});
        else nPass++;
        step();
        sbq.delete();
        rst = 1'b0;
        load_req = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_single_word();
        test_full_load(1, 1'b0);
        test_timeout();
        test_restart();
        test_async_reset();
        test_full_load(0, 1'b1);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
